// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//   Transaction controller sitting behind the SPI slave byte interface. Each
//   SS window is one transaction: the first received byte is a command
//   (bit 7 = read, bits 6:0 = start address), and every following byte either
//   writes the register bank or requests the next read byte for MISO.
//   Addresses auto-increment and wrap at DEPTH-1. User logic observes the bank
//   through a combinational side port that never stalls the SPI path.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   ss_active   in   high while an SPI transaction is open (synchronised SS)
//   rx_data     in   received byte from the shifter
//   rx_valid    in   one-cycle pulse qualifying rx_data
//   tx_data     out  next byte for the MISO shifter
//   tx_load     out  one-cycle pulse: shifter loads tx_data
//   host_addr   in   side-port read address
//   host_rdata  out  mem[host_addr] (combinational, 0 when out of range)
//   wr_strobe   out  one-cycle pulse on each register write
//   wr_addr     out  address of that write
//   txn_done    out  one-cycle pulse when a non-idle transaction closes
//   cmd_err     out  sticky invalid-address flag, cleared by next valid command
//   byte_cnt    out  bytes received in current/last transaction, saturating
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
    parameter int         DEPTH     = 16,
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] IDLE_BYTE = 8'hA5,
    parameter logic [7:0] ERR_BYTE  = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_active,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_load,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [7:0]        host_rdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              txn_done,
    output logic              cmd_err,
    output logic [7:0]        byte_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic              r_ss_q;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nx;
    logic [7:0]        r_mem [DEPTH];

    logic [7:0]        r_tx_data,   w_tx_data_nx;
    logic              r_tx_load,   w_tx_load_nx;
    logic              r_wr_strobe, w_wr_strobe_nx;
    logic [ADDR_W-1:0] r_wr_addr,   w_wr_addr_nx;
    logic              r_txn_done,  w_txn_done_nx;
    logic              r_cmd_err,   w_cmd_err_nx;
    logic [7:0]        r_byte_cnt,  w_byte_cnt_nx;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [7:0]        w_mem_wdata;

    logic              w_cmd_ok;
    logic [ADDR_W-1:0] w_cmd_idx;
    logic              w_host_ok;

    // Pointer increment with an explicit wrap so non-power-of-2 depths work.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(DEPTH - 1)) begin
            return '0;
        end
        return a + ADDR_W'(1);
    endfunction

    // Widen by one bit so DEPTH=128 still compares correctly against 7-bit addresses.
    assign w_cmd_ok  = ({1'b0, rx_data[6:0]} < 8'(DEPTH));
    assign w_cmd_idx = rx_data[ADDR_W-1:0];
    assign w_host_ok = ({1'b0, host_addr} < (ADDR_W + 1)'(DEPTH));

    always_comb begin
        w_state_nx     = r_state;
        w_ptr_nx       = r_ptr;
        w_tx_data_nx   = r_tx_data;
        w_tx_load_nx   = 1'b0;
        w_wr_strobe_nx = 1'b0;
        w_wr_addr_nx   = r_wr_addr;
        w_txn_done_nx  = 1'b0;
        w_cmd_err_nx   = r_cmd_err;
        w_byte_cnt_nx  = r_byte_cnt;
        w_mem_we       = 1'b0;
        w_mem_waddr    = r_ptr;
        w_mem_wdata    = rx_data;

        // Any byte seen inside a transaction is counted, including the one
        // that arrives together with the SS fall.
        if ((r_state != S_IDLE) && rx_valid && (r_byte_cnt != 8'hFF)) begin
            w_byte_cnt_nx = r_byte_cnt + 8'd1;
        end

        case (r_state)
            S_IDLE: begin
                if (ss_active && !r_ss_q) begin
                    w_state_nx    = S_CMD;
                    w_byte_cnt_nx = 8'd0;
                    w_tx_data_nx  = IDLE_BYTE;
                end
            end
            S_CMD: begin
                if (rx_valid) begin
                    if (!w_cmd_ok) begin
                        w_state_nx   = S_ERR;
                        w_cmd_err_nx = 1'b1;
                        w_tx_data_nx = ERR_BYTE;
                    end else begin
                        w_cmd_err_nx = 1'b0;
                        w_ptr_nx     = w_cmd_idx;
                        if (rx_data[7]) begin
                            w_state_nx   = S_READ;
                            w_tx_data_nx = r_mem[w_cmd_idx];
                            w_tx_load_nx = 1'b1;
                            w_ptr_nx     = next_addr(w_cmd_idx);
                        end else begin
                            w_state_nx = S_WRITE;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (rx_valid) begin
                    w_mem_we       = 1'b1;
                    w_mem_waddr    = r_ptr;
                    w_wr_strobe_nx = 1'b1;
                    w_wr_addr_nx   = r_ptr;
                    w_ptr_nx       = next_addr(r_ptr);
                end
            end
            S_READ: begin
                if (rx_valid) begin
                    w_tx_data_nx = r_mem[r_ptr];
                    w_tx_load_nx = 1'b1;
                    w_ptr_nx     = next_addr(r_ptr);
                end
            end
            S_ERR: begin
                w_tx_data_nx = ERR_BYTE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // SS fall closes the transaction; it overrides the state and MISO byte
        // but leaves the byte processed above (write/count/pointer) intact.
        if ((r_state != S_IDLE) && !ss_active) begin
            w_state_nx    = S_IDLE;
            w_txn_done_nx = 1'b1;
            w_tx_data_nx  = IDLE_BYTE;
        end
    end

    // SS history is not reset so a reset during an open window does not
    // look like a fresh SS rise afterwards.
    always_ff @(posedge clk) begin
        r_ss_q <= ss_active;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_tx_data   <= IDLE_BYTE;
            r_tx_load   <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_txn_done  <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_byte_cnt  <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
        end else begin
            r_state     <= w_state_nx;
            r_ptr       <= w_ptr_nx;
            r_tx_data   <= w_tx_data_nx;
            r_tx_load   <= w_tx_load_nx;
            r_wr_strobe <= w_wr_strobe_nx;
            r_wr_addr   <= w_wr_addr_nx;
            r_txn_done  <= w_txn_done_nx;
            r_cmd_err   <= w_cmd_err_nx;
            r_byte_cnt  <= w_byte_cnt_nx;
            if (w_mem_we) begin
                r_mem[w_mem_waddr] <= w_mem_wdata;
            end
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_load    = r_tx_load;
    assign wr_strobe  = r_wr_strobe;
    assign wr_addr    = r_wr_addr;
    assign txn_done   = r_txn_done;
    assign cmd_err    = r_cmd_err;
    assign byte_cnt   = r_byte_cnt;
    assign host_rdata = w_host_ok ? r_mem[host_addr] : 8'h00;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ss_active;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_load;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_rdata;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic              txn_done;
    logic              cmd_err;
    logic [7:0]        byte_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents and sticky error flag.
    logic [7:0] mem_m [DEPTH];
    logic       err_m;

    // Pulse counters sampled on the falling edge.
    int ws_seen   = 0;
    int done_seen = 0;

    spi_reg_ctrl #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IDLE_BYTE(8'hA5), .ERR_BYTE(8'hFF)
    ) dut (
        .clk(clk), .rst(rst), .ss_active(ss_active), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_load(tx_load), .host_addr(host_addr), .host_rdata(host_rdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .txn_done(txn_done), .cmd_err(cmd_err),
        .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) ws_seen++;
        if (txn_done === 1'b1) done_seen++;
    end

    task automatic ss_open();
        @(negedge clk); ss_active = 1'b1;
        @(negedge clk);
    endtask

    task automatic ss_close();
        @(negedge clk); ss_active = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk); rx_data = b; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        err_m = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ss_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; host_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL reset_tx_data got=%h exp=a5", tx_data); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); end
        checks++; if (byte_cnt !== 8'h00) begin errors++; $display("FAIL reset_byte_cnt got=%h exp=00", byte_cnt); end
        checks++; if ({tx_load, wr_strobe, txn_done} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {tx_load, wr_strobe, txn_done}); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
        for (int a = 0; a < DEPTH; a++) begin
            host_addr = ADDR_W'(a); #1;
            checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL reset_mem[%0d] got=%h exp=00", a, host_rdata); end
        end
    endtask

    task automatic test_write_burst();
        int ws0, d0;
        logic [7:0] dat [3];
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
        ss_open();
        #2; ws0 = ws_seen; d0 = done_seen;
        send(8'h03);
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL wb_cmd_strobe got=%b exp=0", wr_strobe); end
        for (int k = 0; k < 3; k++) begin
            send(dat[k]);
            mem_m[3 + k] = dat[k];
            checks++; if (wr_strobe !== 1'b1 || wr_addr !== ADDR_W'(3 + k)) begin errors++; $display("FAIL wb_strobe%0d got=%b/%h exp=1/%h", k, wr_strobe, wr_addr, 3 + k); end
        end
        ss_close();
        checks++; if (txn_done !== 1'b1) begin errors++; $display("FAIL wb_txn_done got=%b exp=1", txn_done); end
        checks++; if (byte_cnt !== 8'd4) begin errors++; $display("FAIL wb_byte_cnt got=%0d exp=4", byte_cnt); end
        @(negedge clk); #2;
        checks++; if (ws_seen - ws0 !== 3) begin errors++; $display("FAIL wb_strobe_count got=%0d exp=3", ws_seen - ws0); end
        checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL wb_done_count got=%0d exp=1", done_seen - d0); end
        for (int a = 3; a < 6; a++) begin
            host_addr = ADDR_W'(a); #1;
            checks++; if (host_rdata !== mem_m[a]) begin errors++; $display("FAIL wb_mem[%0d] got=%h exp=%h", a, host_rdata, mem_m[a]); end
        end
    endtask

    task automatic test_read_burst();
        ss_open();
        send(8'h84);
        checks++; if (tx_load !== 1'b1 || tx_data !== 8'h22) begin errors++; $display("FAIL rd_first got=%b/%h exp=1/22", tx_load, tx_data); end
        send(8'h00);
        checks++; if (tx_load !== 1'b1 || tx_data !== 8'h33) begin errors++; $display("FAIL rd_second got=%b/%h exp=1/33", tx_load, tx_data); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL rd_no_write got=%b exp=0", wr_strobe); end
        send(8'h00);
        ss_close();
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL rd_idle_byte got=%h exp=a5", tx_data); end
    endtask

    task automatic test_wrap();
        ss_open();
        send(8'h0F);
        send(8'hAA);
        checks++; if (wr_addr !== 4'hF) begin errors++; $display("FAIL wrap_addr0 got=%h exp=f", wr_addr); end
        send(8'hBB);
        checks++; if (wr_addr !== 4'h0) begin errors++; $display("FAIL wrap_addr1 got=%h exp=0", wr_addr); end
        ss_close();
        mem_m[15] = 8'hAA; mem_m[0] = 8'hBB;
        host_addr = 4'hF; #1;
        checks++; if (host_rdata !== 8'hAA) begin errors++; $display("FAIL wrap_mem15 got=%h exp=aa", host_rdata); end
        host_addr = 4'h0; #1;
        checks++; if (host_rdata !== 8'hBB) begin errors++; $display("FAIL wrap_mem0 got=%h exp=bb", host_rdata); end
    endtask

    task automatic test_error();
        ss_open();
        send(8'h95);
        err_m = 1'b1;
        checks++; if (cmd_err !== 1'b1 || tx_data !== 8'hFF) begin errors++; $display("FAIL err_cmd got=%b/%h exp=1/ff", cmd_err, tx_data); end
        send(8'h12);
        checks++; if (wr_strobe !== 1'b0 || tx_data !== 8'hFF) begin errors++; $display("FAIL err_data got=%b/%h exp=0/ff", wr_strobe, tx_data); end
        send(8'h34);
        ss_close();
        checks++; if (txn_done !== 1'b1 || cmd_err !== 1'b1 || byte_cnt !== 8'd3) begin errors++; $display("FAIL err_close got=%b/%b/%0d exp=1/1/3", txn_done, cmd_err, byte_cnt); end
        ss_open();
        send(8'h01);
        err_m = 1'b0;
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", cmd_err); end
        send(8'h5A);
        mem_m[1] = 8'h5A;
        checks++; if (wr_strobe !== 1'b1 || wr_addr !== 4'h1) begin errors++; $display("FAIL err_recover got=%b/%h exp=1/1", wr_strobe, wr_addr); end
        ss_close();
    endtask

    task automatic test_abort();
        int ws0, d0;
        ss_open();
        send(8'h02);
        send(8'h77);
        checks++; if (wr_strobe !== 1'b1 || wr_addr !== 4'h2) begin errors++; $display("FAIL ab_first got=%b/%h exp=1/2", wr_strobe, wr_addr); end
        #2; ws0 = ws_seen; d0 = done_seen;
        @(negedge clk); rx_data = 8'h88; rx_valid = 1'b1; rst = 1'b1;
        @(negedge clk); rx_valid = 1'b0; rst = 1'b0;
        model_clear();
        checks++; if (wr_strobe !== 1'b0 || byte_cnt !== 8'd0) begin errors++; $display("FAIL ab_reset got=%b/%0d exp=0/0", wr_strobe, byte_cnt); end
        host_addr = 4'h3; #1;
        checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL ab_second_unstored got=%h exp=00", host_rdata); end
        send(8'h99);
        checks++; if (wr_strobe !== 1'b0 || byte_cnt !== 8'd0) begin errors++; $display("FAIL ab_idle_ignore got=%b/%0d exp=0/0", wr_strobe, byte_cnt); end
        ss_close();
        checks++; if (txn_done !== 1'b0) begin errors++; $display("FAIL ab_no_done got=%b exp=0", txn_done); end
        @(negedge clk); #2;
        checks++; if (ws_seen - ws0 !== 0 || done_seen - d0 !== 0) begin errors++; $display("FAIL ab_counts got=%0d/%0d exp=0/0", ws_seen - ws0, done_seen - d0); end
        // Byte arriving in the same cycle as the SS fall.
        ss_open();
        send(8'h0A);
        send(8'h5C);
        @(negedge clk); rx_data = 8'h6D; rx_valid = 1'b1; ss_active = 1'b0;
        @(negedge clk); rx_valid = 1'b0;
        mem_m[10] = 8'h5C; mem_m[11] = 8'h6D;
        checks++; if (wr_strobe !== 1'b1 || wr_addr !== 4'hB || txn_done !== 1'b1) begin errors++; $display("FAIL ab_fall_byte got=%b/%h/%b exp=1/b/1", wr_strobe, wr_addr, txn_done); end
        checks++; if (byte_cnt !== 8'd3 || tx_data !== 8'hA5) begin errors++; $display("FAIL ab_fall_state got=%0d/%h exp=3/a5", byte_cnt, tx_data); end
        for (int a = 10; a < 12; a++) begin
            host_addr = ADDR_W'(a); #1;
            checks++; if (host_rdata !== mem_m[a]) begin errors++; $display("FAIL ab_mem[%0d] got=%h exp=%h", a, host_rdata, mem_m[a]); end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            int addr, rd, n, a;
            logic [7:0] b;
            addr = int'($urandom_range(0, 23));
            rd   = int'($urandom_range(0, 1));
            n    = int'($urandom_range(1, 5));
            ss_open();
            send({rd[0], addr[6:0]});
            if (addr >= DEPTH) begin
                err_m = 1'b1;
                checks++; if (cmd_err !== 1'b1 || tx_data !== 8'hFF) begin errors++; $display("FAIL rnd%0d_cmd_err got=%b/%h exp=1/ff", t, cmd_err, tx_data); end
            end else begin
                err_m = 1'b0;
                checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL rnd%0d_cmd_ok got=%b exp=0", t, cmd_err); end
                if (rd == 1) begin
                    checks++; if (tx_load !== 1'b1 || tx_data !== mem_m[addr]) begin errors++; $display("FAIL rnd%0d_rd_cmd got=%b/%h exp=1/%h", t, tx_load, tx_data, mem_m[addr]); end
                end
            end
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                send(b);
                a = (addr + k + rd) % DEPTH;
                if (addr >= DEPTH) begin
                    checks++; if (wr_strobe !== 1'b0 || tx_load !== 1'b0 || tx_data !== 8'hFF) begin errors++; $display("FAIL rnd%0d_err_byte%0d got=%b/%b/%h exp=0/0/ff", t, k, wr_strobe, tx_load, tx_data); end
                end else if (rd == 1) begin
                    checks++; if (tx_load !== 1'b1 || tx_data !== mem_m[a]) begin errors++; $display("FAIL rnd%0d_rd%0d got=%b/%h exp=1/%h", t, k, tx_load, tx_data, mem_m[a]); end
                end else begin
                    checks++; if (wr_strobe !== 1'b1 || wr_addr !== ADDR_W'(a)) begin errors++; $display("FAIL rnd%0d_wr%0d got=%b/%h exp=1/%h", t, k, wr_strobe, wr_addr, a); end
                    mem_m[a] = b;
                end
            end
            ss_close();
            checks++; if (txn_done !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL rnd%0d_close got=%b/%h exp=1/a5", t, txn_done, tx_data); end
            checks++; if (byte_cnt !== 8'(n + 1) || cmd_err !== err_m) begin errors++; $display("FAIL rnd%0d_cnt got=%0d/%b exp=%0d/%b", t, byte_cnt, cmd_err, n + 1, err_m); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            host_addr = ADDR_W'(i); #1;
            checks++; if (host_rdata !== mem_m[i]) begin errors++; $display("FAIL rnd_mem[%0d] got=%h exp=%h", i, host_rdata, mem_m[i]); end
        end
    endtask

    task automatic test_saturation();
        ss_open();
        send(8'h80);
        for (int k = 1; k < 260; k++) begin
            send(8'($urandom));
            if (k == 254) begin
                checks++; if (byte_cnt !== 8'd255) begin errors++; $display("FAIL sat_reach got=%0d exp=255", byte_cnt); end
            end
        end
        checks++; if (byte_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got=%0d exp=255", byte_cnt); end
        ss_close();
        send(8'h12);
        checks++; if (wr_strobe !== 1'b0 || tx_load !== 1'b0 || byte_cnt !== 8'd255) begin errors++; $display("FAIL idle_rx_ignored got=%b/%b/%0d exp=0/0/255", wr_strobe, tx_load, byte_cnt); end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_error();
        test_abort();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
